// File: rtl/mix_columns_seq_pkg.sv
// Shared definitions for the sequential MixColumns engine.
// Contents:
//   STATE_W, COL_W        - AES state and column widths
//   AES_POLY              - low byte of the AES reduction polynomial x^8+x^4+x^3+x+1
//   state_t               - engine FSM encoding (IDLE, BUSY, DONE)
//   xtime()               - multiply a byte by x in GF(2^8)
//   col_get() / col_set() - column slicing of a state; column 0 is the MSW
//   byte_get()            - row slicing of a column; row 0 is the MSB byte
package mix_columns_seq_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [COL_W-1:0] col_get(input logic [STATE_W-1:0] s,
                                               input logic [1:0]         idx);
    return s[STATE_W-1-COL_W*int'(idx) -: COL_W];
  endfunction

  function automatic logic [STATE_W-1:0] col_set(input logic [STATE_W-1:0] s,
                                                 input logic [1:0]         idx,
                                                 input logic [COL_W-1:0]   col);
    logic [STATE_W-1:0] r;
    r = s;
    r[STATE_W-1-COL_W*int'(idx) -: COL_W] = col;
    return r;
  endfunction

  function automatic logic [7:0] byte_get(input logic [COL_W-1:0] col,
                                          input logic [1:0]       row);
    return col[COL_W-1-8*int'(row) -: 8];
  endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for mix_columns_seq.
//   in_valid/in_ready/in_data/in_inv : input state stream, in_inv selects InvMixColumns
//   out_valid/out_ready/out_data     : result stream
// Modports: slave = engine side, master = producer/consumer side.
interface mix_columns_seq_if;
  import mix_columns_seq_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_data;
  logic               in_inv;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mix_columns_seq_gf_mix_col.sv
// gf_mix_col: combinational mixing of one AES column.
//   i_col : 32-bit column, row 0 in bits [31:24]
//   i_inv : 0 = MixColumns {02,03,01,01}, 1 = InvMixColumns {0e,0b,0d,09}
//   o_col : mixed column, same layout
// All multiples come from a chain of xtime cells plus XOR.
module gf_mix_col
  import mix_columns_seq_pkg::*;
(
  input  logic [COL_W-1:0] i_col,
  input  logic             i_inv,
  output logic [COL_W-1:0] o_col
);

  logic [7:0] w_a  [4];
  logic [7:0] w_x2 [4];
  logic [7:0] w_x4 [4];
  logic [7:0] w_x8 [4];
  logic [7:0] w_m3 [4];
  logic [7:0] w_m9 [4];
  logic [7:0] w_mb [4];
  logic [7:0] w_md [4];
  logic [7:0] w_me [4];

  for (genvar r = 0; r < 4; r++) begin : g_mul
    assign w_a[r]  = byte_get(i_col, 2'(r));
    assign w_x2[r] = xtime(w_a[r]);
    assign w_x4[r] = xtime(w_x2[r]);
    assign w_x8[r] = xtime(w_x4[r]);
    assign w_m3[r] = w_x2[r] ^ w_a[r];
    assign w_m9[r] = w_x8[r] ^ w_a[r];
    assign w_mb[r] = w_x8[r] ^ w_x2[r] ^ w_a[r];
    assign w_md[r] = w_x8[r] ^ w_x4[r] ^ w_a[r];
    assign w_me[r] = w_x8[r] ^ w_x4[r] ^ w_x2[r];
  end

  // Row r uses the coefficient row rotated right by r positions.
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;
    assign o_col[COL_W-1-8*r -: 8] = i_inv
      ? (w_me[r] ^ w_mb[R1] ^ w_md[R2] ^ w_m9[R3])
      : (w_x2[r] ^ w_m3[R1] ^ w_a[R2]  ^ w_a[R3]);
  end

endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns / InvMixColumns engine.
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : mix_columns_seq_if.slave - input state handshake (with in_inv mode),
//         output state handshake
// COLS_PER_CYCLE (1, 2 or 4) columns are mixed per BUSY cycle, so a block
// takes NCYC = 4/COLS_PER_CYCLE BUSY cycles, then waits in DONE for out_ready.
module mix_columns_seq
  import mix_columns_seq_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  mix_columns_seq_if.slave  bus
);

  localparam int NCYC = 4 / COLS_PER_CYCLE;

  if (!(COLS_PER_CYCLE inside {1, 2, 4})) begin : g_bad_cols
    $fatal(1, "mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t             r_state;
  logic [1:0]         r_cnt;
  logic               r_inv;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [STATE_W-1:0] r_data;

  logic               w_accept;
  logic [STATE_W-1:0] w_data_next;
  logic [1:0]         w_col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0]   w_mix_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0]   w_mix_out [COLS_PER_CYCLE];

  assign w_accept = r_in_ready & bus.in_valid;

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign w_col_idx[k] = 2'(int'(r_cnt) * COLS_PER_CYCLE + k);
    assign w_mix_in[k]  = col_get(r_data, w_col_idx[k]);

    gf_mix_col u_mix (
      .i_col (w_mix_in[k]),
      .i_inv (r_inv),
      .o_col (w_mix_out[k])
    );
  end

  // NOTE: start from the current state so every bit has a value on every
  // path; a missing default here would infer a latch.
  always_comb begin
    w_data_next = r_data;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      w_data_next = col_set(w_data_next, w_col_idx[k], w_mix_out[k]);
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_inv       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_inv      <= bus.in_inv;
            r_cnt      <= 2'd0;
            r_in_ready <= 1'b0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == 2'(NCYC - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: the state register has no reset; its contents are only visible
  // through the r_out_valid gate below, which reset does clear.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data <= bus.in_data;
    end else if (r_state == ST_BUSY) begin
      r_data <= w_data_next;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_valid ? r_data : '0;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: three engines (COLS_PER_CYCLE 1, 2, 4)
// share clk/rst; directed vectors plus a GF(2^8) reference model for random states.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]   tb_in_valid, tb_in_ready, tb_in_inv;
  logic [2:0]   tb_out_valid, tb_out_ready;
  logic [127:0] tb_in_data  [3];
  logic [127:0] tb_out_data [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_seq_if u_if ();

    mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
    );

    assign u_if.in_valid  = tb_in_valid[g];
    assign u_if.in_data   = tb_in_data[g];
    assign u_if.in_inv    = tb_in_inv[g];
    assign u_if.out_ready = tb_out_ready[g];
    assign tb_in_ready[g]  = u_if.in_ready;
    assign tb_out_valid[g] = u_if.out_valid;
    assign tb_out_data[g]  = u_if.out_data;
  end

  localparam logic [127:0] ST_A   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] ST_A_F = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] ST_B   = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
  localparam logic [127:0] ST_B_F = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;

  // Shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [127:0] r = '0;
    logic [7:0]   acc;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gf_mul(coef[(j - row + 4) % 4], s[127-32*c-8*j -: 8]);
        end
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full block on engine sel. Inputs are scrambled right after the accept
  // edge, so every block also proves that data and mode are latched at accept.
  task automatic run_block(input int sel, input logic [127:0] d, input logic inv,
                           output logic [127:0] res, output int lat);
    check("in_ready_idle", 128'(tb_in_ready[sel]), 128'(1'b1));
    tb_in_valid[sel]  = 1'b1;
    tb_in_data[sel]   = d;
    tb_in_inv[sel]    = inv;
    tb_out_ready[sel] = 1'b0;
    tick();
    tb_in_valid[sel] = 1'b0;
    tb_in_data[sel]  = ~d;
    tb_in_inv[sel]   = ~inv;
    lat = 0;
    while (!tb_out_valid[sel] && lat < 20) begin
      tick();
      lat++;
    end
    res = tb_out_data[sel];
    tb_out_ready[sel] = 1'b1;
    tick();
    tb_out_ready[sel] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, res2, x;
    logic [127:0] q [8];
    int lat, stray, in_idx, out_idx, cyc, last_cyc;
    bit acc;

    rst          = 1'b1;
    tb_in_valid  = '0;
    tb_in_inv    = '0;
    tb_out_ready = '0;
    for (int k = 0; k < 3; k++) tb_in_data[k] = '0;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      check("reset_in_ready",  128'(tb_in_ready[s]),  128'(1'b1));
      check("reset_out_valid", 128'(tb_out_valid[s]), 128'(1'b0));
      check("reset_out_data",  tb_out_data[s], '0);
    end
    rst = 1'b0;
    tick();

    // Directed forward / inverse vectors.
    run_block(0, ST_A, 1'b0, res, lat);
    check("fwd_A", res, ST_A_F);
    check("lat_fwd_A", 128'(lat), 128'(4));
    run_block(0, ST_B, 1'b0, res, lat);
    check("fwd_B", res, ST_B_F);
    run_block(0, ST_A_F, 1'b1, res, lat);
    check("inv_A", res, ST_A);
    check("lat_inv_A", 128'(lat), 128'(4));
    run_block(0, ST_B_F, 1'b1, res, lat);
    check("inv_B", res, ST_B);
    for (int s = 1; s < 3; s++) begin
      run_block(s, ST_A, 1'b0, res, lat);
      check("fwd_A_wide", res, ST_A_F);
      check("lat_wide", 128'(lat), 128'(4 >> s));
      run_block(s, ST_B_F, 1'b1, res, lat);
      check("inv_B_wide", res, ST_B);
    end

    // Random round trips on every width.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 1000; i++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        run_block(s, x, 1'b0, res, lat);
        check("rand_fwd", res, mix_ref(x, 1'b0));
        check("rand_lat", 128'(lat), 128'(4 >> s));
        run_block(s, res, 1'b1, res2, lat);
        check("rand_round_trip", res2, x);
      end
    end

    // Output backpressure with a competing in_valid.
    tb_in_valid[0] = 1'b1; tb_in_data[0] = ST_A; tb_in_inv[0] = 1'b0;
    tick();
    tb_in_valid[0] = 1'b0;
    lat = 0;
    while (!tb_out_valid[0] && lat < 20) begin tick(); lat++; end
    check("bp_latency", 128'(lat), 128'(4));
    tb_in_valid[0] = 1'b1; tb_in_data[0] = ST_B;
    for (int i = 0; i < 10; i++) begin
      check("bp_data_stable", tb_out_data[0], ST_A_F);
      check("bp_in_ready",    128'(tb_in_ready[0]),  128'(1'b0));
      check("bp_out_valid",   128'(tb_out_valid[0]), 128'(1'b1));
      tick();
    end
    tb_in_valid[0]  = 1'b0;
    tb_out_ready[0] = 1'b1;
    tick();
    tb_out_ready[0] = 1'b0;
    check("bp_release_in_ready",  128'(tb_in_ready[0]),  128'(1'b1));
    check("bp_release_out_valid", 128'(tb_out_valid[0]), 128'(1'b0));
    stray = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (tb_out_valid[0]) stray++; end
    check("bp_ignored_input", 128'(stray), 128'(0));

    // Reset while BUSY at cnt=2.
    tb_in_valid[0] = 1'b1; tb_in_data[0] = ST_B; tb_in_inv[0] = 1'b0;
    tick();
    tb_in_valid[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_busy_in_ready",  128'(tb_in_ready[0]),  128'(1'b1));
    check("rst_busy_out_valid", 128'(tb_out_valid[0]), 128'(1'b0));
    check("rst_busy_out_data",  tb_out_data[0], '0);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (tb_out_valid[0]) stray++; end
    check("rst_busy_no_stale", 128'(stray), 128'(0));

    // Reset while DONE holds a result.
    tb_in_valid[0] = 1'b1; tb_in_data[0] = ST_A;
    tick();
    tb_in_valid[0] = 1'b0;
    lat = 0;
    while (!tb_out_valid[0] && lat < 20) begin tick(); lat++; end
    check("rst_done_reached", 128'(tb_out_valid[0]), 128'(1'b1));
    rst = 1'b1;
    tick();
    check("rst_done_in_ready",  128'(tb_in_ready[0]),  128'(1'b1));
    check("rst_done_out_valid", 128'(tb_out_valid[0]), 128'(1'b0));
    check("rst_done_out_data",  tb_out_data[0], '0);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (tb_out_valid[0]) stray++; end
    check("rst_done_no_stale", 128'(stray), 128'(0));

    // Back-to-back traffic, out_ready held high.
    q[0] = ST_A; q[1] = ST_B; q[2] = ST_A_F;
    for (int i = 3; i < 8; i++) q[i] = {$urandom, $urandom, $urandom, $urandom};
    in_idx = 0; out_idx = 0; cyc = 0; last_cyc = -1;
    tb_out_ready[0] = 1'b1;
    tb_in_valid[0]  = 1'b1;
    tb_in_data[0]   = q[0];
    tb_in_inv[0]    = 1'b0;
    while (out_idx < 8 && cyc < 200) begin
      acc = tb_in_valid[0] && tb_in_ready[0];
      tick();
      cyc++;
      if (acc) begin
        in_idx++;
        if (in_idx < 8) tb_in_data[0] = q[in_idx];
        else tb_in_valid[0] = 1'b0;
      end
      if (tb_out_valid[0]) begin
        check("b2b_data", tb_out_data[0], mix_ref(q[out_idx], 1'b0));
        if (last_cyc >= 0) check("b2b_gap", 128'(cyc - last_cyc), 128'(6));
        last_cyc = cyc;
        out_idx++;
      end
    end
    check("b2b_count", 128'(out_idx), 128'(8));
    tb_in_valid[0] = 1'b0;
    tick();
    tb_out_ready[0] = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
